// File: rtl/rs_dispatch_sink.sv
// Dispatch receiver: two in-order reservation stations (add/sub, mul/div) with a register
// busy scoreboard cleared by the CDB. Define RS_STATS_EN to add dispatch/drop counters.
module rs_dispatch_sink #(
    parameter int unsigned AS_DEPTH = 3,
    parameter int unsigned MD_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_clear,
`ifdef RS_STATS_EN
    output logic [15:0] o_disp_cnt,
    output logic [15:0] o_drop_cnt,
`endif
    input  logic        i_disp_valid,
    input  logic [8:0]  i_instr,
    output logic        o_as_full,
    output logic        o_md_full,
    output logic        o_as_valid,
    input  logic        i_as_ready,
    output logic [2:0]  o_as_op,
    output logic [2:0]  o_as_rd,
    output logic [2:0]  o_as_rs,
    output logic        o_md_valid,
    input  logic        i_md_ready,
    output logic [2:0]  o_md_op,
    output logic [2:0]  o_md_rd,
    output logic [2:0]  o_md_rs,
    input  logic        i_cdb_valid,
    input  logic [2:0]  i_cdb_reg
);

    localparam int unsigned AW       = $clog2(AS_DEPTH + 1);
    localparam int unsigned MW       = $clog2(MD_DEPTH + 1);
    // Storage is rounded up to a power of two so pointer width matches the index width.
    localparam int unsigned AS_SLOTS = 1 << AW;
    localparam int unsigned MD_SLOTS = 1 << MW;
    localparam logic [AW-1:0] AS_CAP  = AW'(AS_DEPTH);
    localparam logic [AW-1:0] AS_LAST = AW'(AS_DEPTH - 1);
    localparam logic [MW-1:0] MD_CAP  = MW'(MD_DEPTH);
    localparam logic [MW-1:0] MD_LAST = MW'(MD_DEPTH - 1);

    logic [8:0]    r_as_mem [AS_SLOTS];
    logic [AW-1:0] r_as_head;
    logic [AW-1:0] r_as_tail;
    logic [AW-1:0] r_as_cnt;
    logic          r_as_full;

    logic [8:0]    r_md_mem [MD_SLOTS];
    logic [MW-1:0] r_md_head;
    logic [MW-1:0] r_md_tail;
    logic [MW-1:0] r_md_cnt;
    logic          r_md_full;

    logic [7:0]    r_busy;

    logic [2:0]    w_opc;
    logic          w_as_push;
    logic          w_md_push;
    logic [8:0]    w_as_head;
    logic [8:0]    w_md_head;
    logic          w_as_ne;
    logic          w_md_ne;
    logic          w_as_rdy;
    logic          w_md_rdy;
    logic          w_rd_conflict;
    logic          w_as_pop;
    logic          w_md_pop;
    logic [AW-1:0] w_as_head_inc;
    logic [AW-1:0] w_as_tail_inc;
    logic [AW-1:0] w_as_cnt_next;
    logic [MW-1:0] w_md_head_inc;
    logic [MW-1:0] w_md_tail_inc;
    logic [MW-1:0] w_md_cnt_next;
    logic [7:0]    w_busy_next;

    // Dispatch decode; opcode 1xx is never accepted.
    assign w_opc     = i_instr[8:6];
    assign w_as_push = i_disp_valid & ~w_opc[2] & ~w_opc[1] & (r_as_cnt < AS_CAP);
    assign w_md_push = i_disp_valid & ~w_opc[2] &  w_opc[1] & (r_md_cnt < MD_CAP);

    assign w_as_head = r_as_mem[r_as_head];
    assign w_md_head = r_md_mem[r_md_head];
    assign w_as_ne   = (r_as_cnt != '0);
    assign w_md_ne   = (r_md_cnt != '0);

    assign w_as_rdy = w_as_ne & ~r_busy[w_as_head[5:3]] & ~r_busy[w_as_head[2:0]];
    assign w_md_rdy = w_md_ne & ~r_busy[w_md_head[5:3]] & ~r_busy[w_md_head[2:0]];

    // Both heads writing the same rd: add/sub wins, mul/div waits.
    assign w_rd_conflict = w_as_rdy & w_md_rdy & (w_as_head[5:3] == w_md_head[5:3]);

    assign o_as_valid = w_as_rdy;
    assign o_md_valid = w_md_rdy & ~w_rd_conflict;
    assign w_as_pop   = o_as_valid & i_as_ready;
    assign w_md_pop   = o_md_valid & i_md_ready;

    assign o_as_op = w_as_ne ? w_as_head[8:6] : 3'd0;
    assign o_as_rd = w_as_ne ? w_as_head[5:3] : 3'd0;
    assign o_as_rs = w_as_ne ? w_as_head[2:0] : 3'd0;
    assign o_md_op = w_md_ne ? w_md_head[8:6] : 3'd0;
    assign o_md_rd = w_md_ne ? w_md_head[5:3] : 3'd0;
    assign o_md_rs = w_md_ne ? w_md_head[2:0] : 3'd0;

    assign o_as_full = r_as_full;
    assign o_md_full = r_md_full;

    assign w_as_head_inc = (r_as_head == AS_LAST) ? '0 : r_as_head + 1'b1;
    assign w_as_tail_inc = (r_as_tail == AS_LAST) ? '0 : r_as_tail + 1'b1;
    assign w_md_head_inc = (r_md_head == MD_LAST) ? '0 : r_md_head + 1'b1;
    assign w_md_tail_inc = (r_md_tail == MD_LAST) ? '0 : r_md_tail + 1'b1;

    always_comb begin
        w_as_cnt_next = r_as_cnt;
        case ({w_as_push, w_as_pop})
            2'b10:   w_as_cnt_next = r_as_cnt + 1'b1;
            2'b01:   w_as_cnt_next = r_as_cnt - 1'b1;
            default: w_as_cnt_next = r_as_cnt;
        endcase
    end

    always_comb begin
        w_md_cnt_next = r_md_cnt;
        case ({w_md_push, w_md_pop})
            2'b10:   w_md_cnt_next = r_md_cnt + 1'b1;
            2'b01:   w_md_cnt_next = r_md_cnt - 1'b1;
            default: w_md_cnt_next = r_md_cnt;
        endcase
    end

    // Clear first so an issue to the same register in this cycle leaves it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (i_cdb_valid) begin
            w_busy_next[i_cdb_reg] = 1'b0;
        end
        if (w_as_pop) begin
            w_busy_next[w_as_head[5:3]] = 1'b1;
        end
        if (w_md_pop) begin
            w_busy_next[w_md_head[5:3]] = 1'b1;
        end
    end

    // Entry storage needs no reset: reads are masked while a station is empty.
    always_ff @(posedge i_clk) begin
        if (!i_clear && w_as_push) begin
            r_as_mem[r_as_tail] <= i_instr;
        end
        if (!i_clear && w_md_push) begin
            r_md_mem[r_md_tail] <= i_instr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_as_head <= '0;
            r_as_tail <= '0;
            r_as_cnt  <= '0;
            r_as_full <= 1'b0;
            r_md_head <= '0;
            r_md_tail <= '0;
            r_md_cnt  <= '0;
            r_md_full <= 1'b0;
            r_busy    <= '0;
        end else begin
            if (w_as_push) begin
                r_as_tail <= w_as_tail_inc;
            end
            if (w_as_pop) begin
                r_as_head <= w_as_head_inc;
            end
            if (w_md_push) begin
                r_md_tail <= w_md_tail_inc;
            end
            if (w_md_pop) begin
                r_md_head <= w_md_head_inc;
            end
            r_as_cnt  <= w_as_cnt_next;
            r_as_full <= (w_as_cnt_next == AS_CAP);
            r_md_cnt  <= w_md_cnt_next;
            r_md_full <= (w_md_cnt_next == MD_CAP);
            r_busy    <= w_busy_next;
        end
    end

`ifdef RS_STATS_EN
    logic        w_drop;
    logic [15:0] r_disp_cnt;
    logic [15:0] r_drop_cnt;

    assign w_drop = i_disp_valid & ~w_as_push & ~w_md_push;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_disp_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_as_push || w_md_push) begin
                r_disp_cnt <= r_disp_cnt + 16'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_disp_cnt = r_disp_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_rs_dispatch_sink.sv
// Directed bench for rs_dispatch_sink: queue scoreboard of expected issues per station,
// checked on every handshake, plus directed checks of flags, latency and hazards.
module tb_rs_dispatch_sink;

    localparam int unsigned AS_DEPTH = 3;
    localparam int unsigned MD_DEPTH = 2;

    logic       clk = 1'b0;
    logic       i_clear = 1'b1;
    logic       i_disp_valid = 1'b0;
    logic [8:0] i_instr = '0;
    logic       o_as_full, o_md_full;
    logic       o_as_valid, o_md_valid;
    logic       i_as_ready = 1'b0;
    logic       i_md_ready = 1'b0;
    logic [2:0] o_as_op, o_as_rd, o_as_rs;
    logic [2:0] o_md_op, o_md_rd, o_md_rs;
    logic       i_cdb_valid = 1'b0;
    logic [2:0] i_cdb_reg = '0;
`ifdef RS_STATS_EN
    logic [15:0] o_disp_cnt, o_drop_cnt;
`endif

    always #5 clk = ~clk;

    rs_dispatch_sink #(
        .AS_DEPTH(AS_DEPTH),
        .MD_DEPTH(MD_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_clear     (i_clear),
`ifdef RS_STATS_EN
        .o_disp_cnt  (o_disp_cnt),
        .o_drop_cnt  (o_drop_cnt),
`endif
        .i_disp_valid(i_disp_valid),
        .i_instr     (i_instr),
        .o_as_full   (o_as_full),
        .o_md_full   (o_md_full),
        .o_as_valid  (o_as_valid),
        .i_as_ready  (i_as_ready),
        .o_as_op     (o_as_op),
        .o_as_rd     (o_as_rd),
        .o_as_rs     (o_as_rs),
        .o_md_valid  (o_md_valid),
        .i_md_ready  (i_md_ready),
        .o_md_op     (o_md_op),
        .o_md_rd     (o_md_rd),
        .o_md_rs     (o_md_rs),
        .i_cdb_valid (i_cdb_valid),
        .i_cdb_reg   (i_cdb_reg)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int disp_exp = 0;
    int drop_exp = 0;
    logic [8:0] as_q[$];
    logic [8:0] md_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one dispatch; the model decides acceptance from start-of-cycle occupancy.
    task automatic disp(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        logic [8:0] ins;
        ins = {op, rd, rs};
        i_disp_valid = 1'b1;
        i_instr = ins;
        if (op[2]) begin
            drop_exp++;
        end else if (!op[1]) begin
            if (as_q.size() < int'(AS_DEPTH)) begin
                as_q.push_back(ins);
                disp_exp++;
            end else begin
                drop_exp++;
            end
        end else begin
            if (md_q.size() < int'(MD_DEPTH)) begin
                md_q.push_back(ins);
                disp_exp++;
            end else begin
                drop_exp++;
            end
        end
    endtask

    task automatic cdb(input logic [2:0] r);
        i_cdb_valid = 1'b1;
        i_cdb_reg = r;
    endtask

    // Score any handshake that completes at the coming edge, then advance one cycle.
    task automatic cyc();
        logic [8:0] expv;
        if (o_as_valid && i_as_ready) begin
            if (as_q.size() == 0) begin
                chk("as_extra_issue", {7'd0, o_as_op, o_as_rd, o_as_rs}, 16'hffff);
            end else begin
                expv = as_q.pop_front();
                chk("as_issue", {7'd0, o_as_op, o_as_rd, o_as_rs}, {7'd0, expv});
            end
        end
        if (o_md_valid && i_md_ready) begin
            if (md_q.size() == 0) begin
                chk("md_extra_issue", {7'd0, o_md_op, o_md_rd, o_md_rs}, 16'hffff);
            end else begin
                expv = md_q.pop_front();
                chk("md_issue", {7'd0, o_md_op, o_md_rd, o_md_rs}, {7'd0, expv});
            end
        end
        @(posedge clk);
        @(negedge clk);
        i_disp_valid = 1'b0;
        i_cdb_valid = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_clear = 1'b0;
        i_disp_valid = 1'b0;
        i_cdb_valid = 1'b0;
        as_q.delete();
        md_q.delete();
        disp_exp = 0;
        drop_exp = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_as_full"},  o_as_full,  0);
        chk({tag, "_md_full"},  o_md_full,  0);
        chk({tag, "_as_valid"}, o_as_valid, 0);
        chk({tag, "_md_valid"}, o_md_valid, 0);
        chk({tag, "_as_fields"}, {o_as_op, o_as_rd, o_as_rs}, 0);
        chk({tag, "_md_fields"}, {o_md_op, o_md_rd, o_md_rs}, 0);
`ifdef RS_STATS_EN
        chk({tag, "_disp_cnt"}, o_disp_cnt, 0);
        chk({tag, "_drop_cnt"}, o_drop_cnt, 0);
`endif
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_clear = 1'b0;
        check_idle("reset");

        // ADD r1,r2 issues one cycle after acceptance
        i_as_ready = 1'b1;
        disp(3'b000, 3'd1, 3'd2);
        cyc();
        chk("t1_as_valid", o_as_valid, 1);
        chk("t1_as_op", o_as_op, 3'b000);
        chk("t1_as_rd", o_as_rd, 3'd1);
        chk("t1_as_rs", o_as_rs, 3'd2);
        cyc();
        chk("t1_as_empty", o_as_valid, 0);
        i_as_ready = 1'b0;

        // MUL r3,r1 waits for busy[1]; unrelated CDB is ignored
        disp(3'b010, 3'd3, 3'd1);
        cyc();
        chk("t3_md_blocked", o_md_valid, 0);
        chk("t3_md_op", o_md_op, 3'b010);
        cdb(3'd6);
        cyc();
        chk("t3_cdb_other", o_md_valid, 0);
        cdb(3'd1);
        cyc();
        chk("t3_md_woken", o_md_valid, 1);
        i_md_ready = 1'b1;
        cyc();
        i_md_ready = 1'b0;
        chk("t3_md_empty", o_md_valid, 0);

        // Fill add/sub station, fourth dispatch dropped
        disp(3'b001, 3'd2, 3'd5);
        cyc();
        chk("t2_full_1", o_as_full, 0);
        disp(3'b001, 3'd5, 3'd6);
        cyc();
        chk("t2_full_2", o_as_full, 0);
        disp(3'b001, 3'd6, 3'd7);
        cyc();
        chk("t2_full_3", o_as_full, 1);
        disp(3'b001, 3'd0, 3'd0);
        cyc();
        chk("t2_full_drop", o_as_full, 1);
        chk("t2_head_valid", o_as_valid, 1);
        chk("t2_head_rd", o_as_rd, 3'd2);

        // Dispatch and issue on a full station: dispatch dropped, flag falls
        disp(3'b000, 3'd7, 3'd7);
        i_as_ready = 1'b1;
        cyc();
        chk("t4_full_fall", o_as_full, 0);
        for (int k = 0; k < 10 && as_q.size() > 0; k++) begin
            cyc();
        end
        chk("t4_drained", as_q.size(), 0);
        chk("t4_as_valid", o_as_valid, 0);
        i_as_ready = 1'b0;
`ifdef RS_STATS_EN
        chk("stats_disp_a", o_disp_cnt, disp_exp);
        chk("stats_drop_a", o_drop_cnt, drop_exp);
`endif

        // Same-rd conflict between heads, then set-wins on the scoreboard
        do_clear();
        check_idle("clr1");
        disp(3'b000, 3'd4, 3'd0);
        cyc();
        disp(3'b010, 3'd4, 3'd1);
        cyc();
        chk("t5_as_valid", o_as_valid, 1);
        chk("t5_md_conflict", o_md_valid, 0);
        chk("t5_md_rd", o_md_rd, 3'd4);
        i_as_ready = 1'b1;
        i_md_ready = 1'b1;
        cyc();
        i_as_ready = 1'b0;
        chk("t5_md_busy4", o_md_valid, 0);
        chk("t5_as_empty", o_as_valid, 0);
        cdb(3'd4);
        cyc();
        chk("t5_md_woken", o_md_valid, 1);
        cdb(3'd4);
        cyc();
        i_md_ready = 1'b0;
        disp(3'b000, 3'd5, 3'd4);
        cyc();
        chk("t5_set_wins", o_as_valid, 0);
        cdb(3'd4);
        cyc();
        chk("t5_as_woken", o_as_valid, 1);

        // Invalid opcode, then clear with pending entries and busy registers
        disp(3'b100, 3'd1, 3'd2);
        cyc();
        chk("t6_md_none", o_md_valid, 0);
        chk("t6_md_fields", {o_md_op, o_md_rd, o_md_rs}, 0);
        chk("t6_as_head", o_as_rd, 3'd5);
        i_as_ready = 1'b1;
        cyc();
        i_as_ready = 1'b0;
        chk("t6_as_empty", o_as_valid, 0);
        disp(3'b010, 3'd6, 3'd7);
        cyc();
        disp(3'b011, 3'd7, 3'd6);
        cyc();
        chk("t6_md_full", o_md_full, 1);
        chk("t6_md_head_op", o_md_op, 3'b010);
`ifdef RS_STATS_EN
        chk("stats_disp_b", o_disp_cnt, disp_exp);
        chk("stats_drop_b", o_drop_cnt, drop_exp);
`endif
        i_disp_valid = 1'b1;
        i_instr = 9'b000_011_011;
        do_clear();
        check_idle("clr2");
        i_as_ready = 1'b1;
        disp(3'b000, 3'd1, 3'd5);
        cyc();
        chk("t6_busy_lost", o_as_valid, 1);
        cyc();
        chk("t6_final_empty", as_q.size(), 0);
        i_as_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
